// File: rtl/lsu_req_stage.sv
// LSU request stage: one load/store per transaction, alignment check,
// bus handshake with timeout, and extended load result toward WBU.
module lsu_req_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TMO_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic [ADDR_W-1:0] lsu_araddr,
  output logic              lsu_arvalid,
  output logic [7:0]        lsu_rstrb,
  input  logic [DATA_W-1:0] lsu_rdata,
  input  logic              lsu_rvalid,
  output logic [ADDR_W-1:0] lsu_awaddr,
  output logic              lsu_awvalid,
  output logic [DATA_W-1:0] lsu_wdata,
  output logic [7:0]        lsu_wstrb,
  output logic              lsu_wvalid,
  input  logic              lsu_wready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic [1:0]        out_fault
);

  typedef enum logic [1:0] {
    IDLE, LOAD, STORE, DONE
  } state_t;

  localparam logic [1:0] OP_LD = 2'd1;
  localparam logic [1:0] OP_ST = 2'd2;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        op_q, op_d;
  logic [7:0]        strb_q, strb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        fault_q, fault_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic              is_ld;
  logic              is_st;
  logic              mis;
  logic [7:0]        strb_new;
  logic [DATA_W-1:0] ld_ext;
  logic [TMO_W-1:0]  cnt_inc;
  logic              tmo_hit;

  assign in_ready = rst && (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_ld    = (in_op == OP_LD);
  assign is_st    = (in_op == OP_ST);

  assign mis = ((in_funct3[1:0] == 2'd1) && in_addr[0]) ||
               (in_funct3[1] && (in_addr[1:0] != 2'd0));

  // Counter value this pending cycle; all-ones marks the last one.
  assign cnt_inc = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
  assign tmo_hit = &cnt_inc;

  always_comb begin
    strb_new = 8'h0f;
    unique case (1'b1)
      (in_funct3[1:0] == 2'd0): strb_new = 8'h01;
      (in_funct3[1:0] == 2'd1): strb_new = 8'h03;
      default:                  strb_new = 8'h0f;
    endcase
  end

  always_comb begin
    ld_ext = lsu_rdata;
    unique case (funct3_q)
      3'd0: ld_ext = {{(DATA_W-8){lsu_rdata[7]}},
                      lsu_rdata[7:0]};
      3'd1: ld_ext = {{(DATA_W-16){lsu_rdata[15]}},
                      lsu_rdata[15:0]};
      3'd4: ld_ext = {{(DATA_W-8){1'b0}},
                      lsu_rdata[7:0]};
      3'd5: ld_ext = {{(DATA_W-16){1'b0}},
                      lsu_rdata[15:0]};
      default: ld_ext = lsu_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    op_d     = op_q;
    strb_d   = strb_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = in_addr;
          funct3_d = in_funct3;
          wdata_d  = in_wdata;
          op_d     = in_op;
          strb_d   = strb_new;
          rdata_d  = '0;
          fault_d  = 2'd0;
          cnt_d    = '0;
          if ((is_ld || is_st) && mis) begin
            fault_d = 2'd1;
            state_d = DONE;
          end else if (is_ld) begin
            state_d = LOAD;
          end else if (is_st) begin
            state_d = STORE;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        cnt_d = cnt_inc;
        if (lsu_rvalid && (op_q == OP_LD)) begin
          rdata_d = ld_ext;
          state_d = DONE;
        end else if (tmo_hit) begin
          fault_d = 2'd2;
          state_d = DONE;
        end
      end
      STORE: begin
        cnt_d = cnt_inc;
        if (lsu_wready) begin
          state_d = DONE;
        end else if (tmo_hit) begin
          fault_d = 2'd2;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      op_q     <= '0;
      strb_q   <= '0;
      rdata_q  <= '0;
      fault_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      op_q     <= op_d;
      strb_q   <= strb_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

  assign lsu_arvalid = (state_q == LOAD);
  assign lsu_araddr  = addr_q;
  assign lsu_rstrb   = strb_q;
  assign lsu_awvalid = (state_q == STORE);
  assign lsu_wvalid  = (state_q == STORE);
  assign lsu_awaddr  = addr_q;
  assign lsu_wdata   = wdata_q;
  assign lsu_wstrb   = strb_q;
  assign out_valid   = (state_q == DONE);
  assign out_rdata   = rdata_q;
  assign out_fault   = fault_q;

endmodule

// File: tb/tb_lsu_req_stage.sv
// Randomized bench for lsu_req_stage against a transaction-level model.
// Drives and samples on the falling edge.
module tb_lsu_req_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [31:0] lsu_araddr;
  logic        lsu_arvalid;
  logic [7:0]  lsu_rstrb;
  logic [31:0] lsu_rdata = '0;
  logic        lsu_rvalid = 1'b0;
  logic [31:0] lsu_awaddr;
  logic        lsu_awvalid;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wstrb;
  logic        lsu_wvalid;
  logic        lsu_wready = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic [1:0]  out_fault;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_req_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_funct3   (in_funct3),
    .in_addr     (in_addr),
    .in_wdata    (in_wdata),
    .lsu_araddr  (lsu_araddr),
    .lsu_arvalid (lsu_arvalid),
    .lsu_rstrb   (lsu_rstrb),
    .lsu_rdata   (lsu_rdata),
    .lsu_rvalid  (lsu_rvalid),
    .lsu_awaddr  (lsu_awaddr),
    .lsu_awvalid (lsu_awvalid),
    .lsu_wdata   (lsu_wdata),
    .lsu_wstrb   (lsu_wstrb),
    .lsu_wvalid  (lsu_wvalid),
    .lsu_wready  (lsu_wready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rdata   (out_rdata),
    .out_fault   (out_fault)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [31:0] rd,
                                      input logic [2:0] f3);
    logic [31:0] b, h;
    b = rd % 256;
    h = rd % 65536;
    case (f3)
      3'd0: return (b >= 128) ? b - 256 : b;
      3'd1: return (h >= 32768) ? h - 65536 : h;
      3'd4: return b;
      3'd5: return h;
      default: return rd;
    endcase
  endfunction

  task automatic garbage_in();
    in_valid  = 1'($urandom % 2);
    in_op     = 2'($urandom);
    in_funct3 = 3'($urandom);
    in_addr   = $urandom;
    in_wdata  = $urandom;
  endtask

  task automatic txn(input logic [1:0] op,
                     input logic [2:0] f3,
                     input logic [31:0] addr,
                     input logic [31:0] wd,
                     input logic [31:0] rd,
                     input int lat,
                     input int hold);
    int sz, busy;
    bit mem, mis, ld;
    logic [7:0] estrb;
    logic [1:0] efault;
    logic [31:0] erdata;
    sz = 1 << (f3 % 4 == 3 ? 2 : f3 % 4);
    mem = (op == 2'd1) || (op == 2'd2);
    ld = (op == 2'd1);
    mis = mem && (addr % sz != 0);
    estrb = 8'((1 << sz) - 1);
    busy = (lat <= 255) ? lat : 255;
    if (!mem || mis) begin
      efault = mis ? 2'd1 : 2'd0;
      erdata = 0;
    end else begin
      efault = (lat <= 255) ? 2'd0 : 2'd2;
      erdata = (ld && lat <= 255) ? ext(rd, f3) : 0;
    end
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    in_valid  = 1'b1;
    in_op     = op;
    in_funct3 = f3;
    in_addr   = addr;
    in_wdata  = wd;
    out_ready = 1'b0;
    @(negedge clk);
    garbage_in();
    if (mem && !mis) begin
      for (int c = 1; c <= busy; c++) begin
        chk("busy_in_ready", in_ready, 0);
        chk("busy_out_valid", out_valid, 0);
        if (ld) begin
          chk("arvalid", lsu_arvalid, 1);
          chk("awvalid_in_ld", lsu_awvalid, 0);
          chk("araddr", lsu_araddr, addr);
          chk("rstrb", lsu_rstrb, estrb);
          lsu_rvalid = (c == lat);
          lsu_rdata  = (c == lat) ? rd : $urandom;
          lsu_wready = 1'($urandom % 2);
        end else begin
          chk("awvalid", lsu_awvalid, 1);
          chk("wvalid", lsu_wvalid, 1);
          chk("arvalid_in_st", lsu_arvalid, 0);
          chk("awaddr", lsu_awaddr, addr);
          chk("wdata", lsu_wdata, wd);
          chk("wstrb", lsu_wstrb, estrb);
          lsu_wready = (c == lat);
          lsu_rvalid = 1'($urandom % 2);
          lsu_rdata  = $urandom;
        end
        @(negedge clk);
        garbage_in();
      end
      lsu_rvalid = 1'b0;
      lsu_wready = 1'b0;
    end
    for (int h = 0; h <= hold; h++) begin
      chk("done_out_valid", out_valid, 1);
      chk("done_rdata", out_rdata, erdata);
      chk("done_fault", out_fault, efault);
      chk("done_in_ready", in_ready, 0);
      chk("done_arvalid", lsu_arvalid, 0);
      chk("done_awvalid", lsu_awvalid, 0);
      if (h == hold) begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
        lsu_rvalid = 1'b0;
        lsu_wready = 1'b0;
      end else begin
        garbage_in();
        lsu_rvalid = 1'($urandom % 2);
        lsu_wready = 1'($urandom % 2);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    lsu_rvalid = 1'b0;
    lsu_wready = 1'b0;
    chk("post_out_valid", out_valid, 0);
  endtask

  task automatic reset_mid_store();
    @(negedge clk);
    in_valid  = 1'b1;
    in_op     = 2'd2;
    in_funct3 = 3'd2;
    in_addr   = 32'h8000_0200;
    in_wdata  = 32'h1234_5678;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rst_pre_awvalid", lsu_awvalid, 1);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    chk("rst_awvalid", lsu_awvalid, 0);
    chk("rst_wvalid", lsu_wvalid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    @(negedge clk);
    chk("rel_out_valid", out_valid, 0);
    chk("rel_awvalid", lsu_awvalid, 0);
  endtask

  initial begin
    logic [2:0] f3s [5];
    logic [1:0] op;
    logic [2:0] f3;
    int r, lat;
    f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd2;
    f3s[3] = 3'd4; f3s[4] = 3'd5;
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_arvalid", lsu_arvalid, 0);
    chk("reset_awvalid", lsu_awvalid, 0);
    chk("reset_wvalid", lsu_wvalid, 0);
    chk("reset_rdata", out_rdata, 0);
    chk("reset_fault", out_fault, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);

    txn(2'd1, 3'd0, 32'h8000_0003, 0, 32'h0000_0080, 2, 0);
    txn(2'd1, 3'd5, 32'h8000_0002, 0, 32'h0000_F00D, 1, 0);
    txn(2'd1, 3'd1, 32'h8000_0002, 0, 32'h0000_F00D, 3, 1);
    txn(2'd2, 3'd2, 32'h8000_0100, 32'hDEAD_BEEF, 0, 3, 0);
    txn(2'd1, 3'd2, 32'h8000_0002, 0, 32'h1111_1111, 1, 0);
    txn(2'd2, 3'd1, 32'h8000_0001, 32'h5555, 0, 1, 0);
    txn(2'd1, 3'd2, 32'h8000_0010, 0, 32'hCAFE_F00D, 1000, 0);
    txn(2'd1, 3'd2, 32'h8000_0014, 0, 32'hA5A5_5A5A, 255, 0);
    txn(2'd2, 3'd0, 32'h8000_0021, 32'h77, 0, 1000, 0);
    txn(2'd0, 3'd2, 32'h8000_0003, 0, 0, 1, 0);
    txn(2'd3, 3'd0, 32'h8000_0000, 0, 0, 1, 2);
    txn(2'd1, 3'd4, 32'h8000_0007, 0, 32'h0000_00FF, 4, 5);

    reset_mid_store();

    for (int i = 0; i < 80; i++) begin
      op = 2'($urandom);
      f3 = f3s[$urandom % 5];
      r = $urandom % 20;
      lat = (r == 0) ? 300 : (r == 1) ? 255 : 1 + $urandom % 5;
      txn(op, f3, $urandom, $urandom, $urandom, lat,
          $urandom % 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_req_stage.md
LSU_REQ_STAGE -- requirements
Module: ysyx_lsu_req

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; TMO_W, default 8, bus-timeout counter width.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be, in order (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  EXU request valid
- in_ready  out  1  block can accept a request
- in_op  in  2  0=none, 1=load, 2=store, 3=reserved (treated as none)
- in_funct3  in  3  RV32 size/sign: 0=LB/SB, 1=LH/SH, 2=LW/SW, 4=LBU, 5=LHU
- in_addr  in  ADDR_W  effective address
- in_wdata  in  DATA_W  store data, unshifted
- lsu_araddr  out  ADDR_W  load address to the bus arbiter
- lsu_arvalid  out  1  load request
- lsu_rstrb  out  8  load size strobe, unshifted
- lsu_rdata  in  DATA_W  load data, already right-aligned by the arbiter
- lsu_rvalid  in  1  load data valid
- lsu_awaddr  out  ADDR_W  store address
- lsu_awvalid  out  1  store address valid
- lsu_wdata  out  DATA_W  store data, unshifted
- lsu_wstrb  out  8  store strobe, unshifted
- lsu_wvalid  out  1  store data valid
- lsu_wready  in  1  store accepted
- out_valid  out  1  result valid toward WBU
- out_ready  in  1  WBU accepts the result
- out_rdata  out  DATA_W  extended load result; 0 for stores and none
- out_fault  out  2  0=ok, 1=misaligned, 2=bus timeout

Function
REQ-004 The FSM SHALL have four states, IDLE, LOAD, STORE and DONE, and SHALL reset to IDLE.
REQ-005 in_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a cycle where in_valid and in_ready are both 1.
REQ-006 On acceptance, the block SHALL register addr, funct3, wdata and op.
REQ-007 On acceptance, a misaligned access (halfword with addr[0]=1, or word with addr[1:0]!=0) SHALL go to DONE with fault=1, SHALL NOT issue a bus request, and SHALL leave rdata at 0.
REQ-008 On acceptance, an aligned load SHALL go to LOAD, an aligned store SHALL go to STORE, and op none or reserved SHALL go to DONE with rdata=0 and fault=0.
REQ-009 In LOAD, lsu_arvalid SHALL be 1 and lsu_araddr SHALL equal the registered address, held stable until lsu_rvalid=1.
REQ-010 When lsu_rvalid=1 in LOAD, the block SHALL capture extended data and go to DONE.
REQ-011 Load extension: LB/LH SHALL sign-extend bit 7/15; LBU/LHU SHALL zero-extend; LW SHALL pass all 32 bits.
REQ-012 lsu_rstrb SHALL be 8'h01, 8'h03 or 8'h0f for byte, halfword or word access.
REQ-013 In STORE, lsu_awvalid and lsu_wvalid SHALL both be 1 with lsu_awaddr, lsu_wdata and lsu_wstrb (same encoding as rstrb) held stable until lsu_wready=1, then the FSM SHALL go to DONE.
REQ-014 All lsu_* valid signals SHALL be 0 outside LOAD and STORE, and every lsu_* output SHALL be driven from registers or state only.
REQ-015 A TMO_W-bit counter SHALL clear on entry to LOAD or STORE and increment each cycle the handshake is pending.
REQ-016 When the counter reaches all-ones without a handshake, the FSM SHALL go to DONE with fault=2 and rdata=0.
REQ-017 A handshake arriving on the all-ones cycle SHALL win, giving fault=0.
REQ-018 In DONE, out_valid SHALL be 1; out_rdata and out_fault SHALL be held until out_ready=1, then the FSM SHALL return to IDLE.
REQ-019 There SHALL be no DONE-to-accept bypass; the next request is accepted at the earliest one cycle after the out handshake.
REQ-020 Latency: with acceptance at cycle T, the bus valid SHALL rise at T+1; with rvalid or wready at cycle T+k, out_valid SHALL rise at T+k+1.
REQ-021 lsu_rvalid or lsu_wready asserted while not in the matching state SHALL be ignored.

Reset
REQ-022 While rst=0, the block SHALL asynchronously force state=IDLE, all valid outputs=0, out_rdata=0, out_fault=0, counter=0 and registered address, data and strobes=0.
REQ-023 Reset asserted mid-LOAD or mid-STORE SHALL drop the bus valids in the same cycle with no completion reported.
REQ-024 in_ready SHALL be 0 during reset and 1 in the first cycle after reset release.

Verification
REQ-025 LB at addr 0x80000003 with lsu_rdata=0x00000080 and rvalid at 2 cycles -> araddr=0x80000003, rstrb=0x01, out_rdata=0xFFFFFF80, fault=0.
REQ-026 LHU at addr 0x80000002 with lsu_rdata=0x0000F00D -> out_rdata=0x0000F00D; LH with the same data -> 0xFFFFF00D.
REQ-027 SW at 0x80000100 with wdata 0xDEADBEEF and wready after 3 cycles -> awvalid and wvalid held 3 cycles, wstrb=0x0f, out_valid the next cycle, rdata=0.
REQ-028 LW at 0x80000002 -> no arvalid ever, out_valid at T+1, fault=1; SH at 0x80000001 -> fault=1, no awvalid.
REQ-029 Load with rvalid never asserted -> arvalid held for 255 cycles, then out_fault=2 and arvalid drops; rvalid on exactly the 255th cycle -> fault=0 with data captured.
REQ-030 rst asserted during STORE with wready=0 -> awvalid and wvalid drop immediately, no out_valid, in_ready=1 after release; out_ready held 0 for 5 cycles in DONE -> out_rdata stable and in_ready=0 throughout.
